cpu_sequencer: RTL and testbench

- Multi-cycle control sequencer for the 8-bit CPU.
- Sits between decoder/main_controller and the datapath (pc, instruction register, regfile, flag, data_mem).
- Splits each instruction into fetch / decode / execute / memory / writeback steps, with a request/acknowledge handshake to data memory and a wait-timeout fault.
- Gates every datapath write enable, so architectural state changes only in the defined step.

---
 rtl/cpu_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control sequencer for the 8-bit CPU.
//
// Splits every instruction into FETCH / DECODE / EXEC / MEM / WB steps and
// gates every datapath write enable so architectural state only changes in
// the step that owns it. Data memory accesses use a req/ack handshake guarded
// by a wait counter; if no ack arrives within MEM_TIMEOUT cycles the core
// parks in FAULT. A halt instruction parks the core in HALT. Both are left
// only through reset.
//
// Optional build macro:
//   DEBUG_STEP_EN  adds input 'step' and state STEP_WAIT. After every
//                  retiring instruction the core waits in STEP_WAIT until
//                  step=1, so a held step advances one instruction per pass.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-low reset
//   step         in   (DEBUG_STEP_EN only) single-step advance
//   is_load      in   decoded memory load
//   is_store     in   decoded memory store
//   is_jump      in   decoded unconditional jump
//   is_branch    in   decoded jump-if-flag
//   is_halt      in   decoded halt
//   reg_write    in   non-memory instruction writes rd
//   flag_write   in   instruction updates flag
//   flag         in   current flag value
//   mem_ack      in   data memory completed current access
//   ir_load      out  latch instruction register
//   pc_en        out  update pc
//   pc_sel       out  0 = pc+1, 1 = jump target
//   reg_w_en     out  regfile write strobe
//   reg_mem_sel  out  regfile write data from memory
//   flag_w_en    out  flag write strobe
//   mem_req      out  data memory request
//   mem_we       out  data memory write (with mem_req)
//   halted       out  core halted
//   fault        out  memory timeout fault
//   retired      out  retired-instruction count (wraps)

module cpu_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
`ifdef DEBUG_STEP_EN
  input  logic             step,
`endif
  input  logic             clock,
  input  logic             reset,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_jump,
  input  logic             is_branch,
  input  logic             is_halt,
  input  logic             reg_write,
  input  logic             flag_write,
  input  logic             flag,
  input  logic             mem_ack,
  output logic             ir_load,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             reg_w_en,
  output logic             reg_mem_sel,
  output logic             flag_w_en,
  output logic             mem_req,
  output logic             mem_we,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    BOOT, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT, STEP_WAIT
  } state_t;

  // Where a retiring instruction goes next: straight to FETCH normally,
  // or to the single-step gate in debug builds.
`ifdef DEBUG_STEP_EN
  localparam state_t RETIRE_NEXT = STEP_WAIT;
`else
  localparam state_t RETIRE_NEXT = FETCH;
`endif

  // Last wait-counter value allowed before the access is declared dead.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       waitCnt_q, waitCnt_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  // State, wait counter and retire counter registers. Reset is asynchronous
  // so an in-flight mem_req drops the moment reset is asserted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= BOOT;
      waitCnt_q <= 8'd0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic. EXEC resolves the instruction class with priority
  // halt > memory > jump/branch > ALU. In MEM an ack beats the timeout.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    case (state_q)
      BOOT:   state_d = FETCH;
      FETCH:  state_d = DECODE;
      DECODE: state_d = EXEC;
      EXEC: begin
        if (is_halt) begin
          state_d = HALT;
        end else if (is_load || is_store) begin
          state_d   = MEM;
          waitCnt_d = 8'd0;
        end else begin
          state_d = RETIRE_NEXT;
        end
      end
      MEM: begin
        if (mem_ack) begin
          state_d = is_store ? RETIRE_NEXT : WB;
        end else begin
          waitCnt_d = waitCnt_q + 8'd1;
          if (waitCnt_q == TIMEOUT_LAST) begin
            state_d = FAULT;
          end
        end
      end
      WB:     state_d = RETIRE_NEXT;
      HALT:   state_d = HALT;
      FAULT:  state_d = FAULT;
`ifdef DEBUG_STEP_EN
      STEP_WAIT: if (step) state_d = FETCH;
`endif
      default: state_d = BOOT;
    endcase
  end

  // Output decode: combinational from state and decoded inputs. Anything
  // not explicitly raised here stays low, which keeps BOOT, DECODE, HALT,
  // FAULT and STEP_WAIT strobe-free.
  always_comb begin
    ir_load     = 1'b0;
    pc_en       = 1'b0;
    pc_sel      = 1'b0;
    reg_w_en    = 1'b0;
    reg_mem_sel = 1'b0;
    flag_w_en   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    halted      = 1'b0;
    fault       = 1'b0;
    case (state_q)
      FETCH: ir_load = 1'b1;
      EXEC: begin
        if (is_halt || is_load || is_store) begin
          pc_en = 1'b0;
        end else if (is_jump || (is_branch && flag)) begin
          pc_en  = 1'b1;
          pc_sel = 1'b1;
        end else if (is_branch) begin
          pc_en = 1'b1;
        end else begin
          pc_en     = 1'b1;
          reg_w_en  = reg_write;
          flag_w_en = flag_write;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        pc_en   = mem_ack && is_store;
      end
      WB: begin
        reg_w_en    = 1'b1;
        reg_mem_sel = 1'b1;
        pc_en       = 1'b1;
      end
      HALT:  halted = 1'b1;
      FAULT: fault  = 1'b1;
      default: ;
    endcase
  end

  // Every pc update retires exactly one instruction.
  assign retired_d = pc_en ? retired_q + {{(CNT_W-1){1'b0}}, 1'b1} : retired_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed bench for cpu_sequencer. Each cycle the bench
// sets the decoded inputs, pushes the strobe vector and retire count it
// expects onto a scoreboard queue, then pops and compares against the DUT
// one time unit after the falling edge.

module tb_cpu_sequencer;

  localparam int CNT_W = 16;

  // Expected-strobe bit positions.
  localparam logic [9:0] B_IR   = 10'b10_0000_0000;
  localparam logic [9:0] B_PCEN = 10'b01_0000_0000;
  localparam logic [9:0] B_PSEL = 10'b00_1000_0000;
  localparam logic [9:0] B_RW   = 10'b00_0100_0000;
  localparam logic [9:0] B_RMS  = 10'b00_0010_0000;
  localparam logic [9:0] B_FW   = 10'b00_0001_0000;
  localparam logic [9:0] B_MREQ = 10'b00_0000_1000;
  localparam logic [9:0] B_MWE  = 10'b00_0000_0100;
  localparam logic [9:0] B_HALT = 10'b00_0000_0010;
  localparam logic [9:0] B_FLT  = 10'b00_0000_0001;

  // Instruction encodings: {load,store,jump,branch,halt,reg_write,flag_write,flag}.
  localparam logic [7:0] I_ALU_RF = 8'b0000_0110;
  localparam logic [7:0] I_ALU_R  = 8'b0000_0100;
  localparam logic [7:0] I_ALU_F  = 8'b0000_0010;
  localparam logic [7:0] I_ALU_N  = 8'b0000_0000;
  localparam logic [7:0] I_BR0    = 8'b0001_0000;
  localparam logic [7:0] I_BR1    = 8'b0001_0001;
  localparam logic [7:0] I_JMP    = 8'b0010_0000;
  localparam logic [7:0] I_LOAD   = 8'b1000_0100;
  localparam logic [7:0] I_STORE  = 8'b0100_0000;
  localparam logic [7:0] I_HALTLD = 8'b1000_1000;

  typedef struct {
    logic [9:0]       vec;
    logic [CNT_W-1:0] ret;
    string            tag;
  } exp_t;

  exp_t sb[$];

  logic clock = 1'b0;
  logic reset;
  logic is_load, is_store, is_jump, is_branch, is_halt;
  logic reg_write, flag_write, flag, mem_ack;
  logic ir_load, pc_en, pc_sel, reg_w_en, reg_mem_sel, flag_w_en;
  logic mem_req, mem_we, halted, fault;
  logic [CNT_W-1:0] retired;
`ifdef DEBUG_STEP_EN
  logic step;
`endif

  int compared   = 0;
  int mismatched = 0;
  logic [CNT_W-1:0] expRet;

  always #5 clock = ~clock;

  cpu_sequencer #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
`ifdef DEBUG_STEP_EN
    .step        (step),
`endif
    .clock       (clock),
    .reset       (reset),
    .is_load     (is_load),
    .is_store    (is_store),
    .is_jump     (is_jump),
    .is_branch   (is_branch),
    .is_halt     (is_halt),
    .reg_write   (reg_write),
    .flag_write  (flag_write),
    .flag        (flag),
    .mem_ack     (mem_ack),
    .ir_load     (ir_load),
    .pc_en       (pc_en),
    .pc_sel      (pc_sel),
    .reg_w_en    (reg_w_en),
    .reg_mem_sel (reg_mem_sel),
    .flag_w_en   (flag_w_en),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .halted      (halted),
    .fault       (fault),
    .retired     (retired)
  );

  wire [9:0] obsVec = {ir_load, pc_en, pc_sel, reg_w_en, reg_mem_sel,
                       flag_w_en, mem_req, mem_we, halted, fault};

  // Drive the decoded instruction fields.
  task automatic applyStimulus(input logic [7:0] instr);
    {is_load, is_store, is_jump, is_branch, is_halt,
     reg_write, flag_write, flag} = instr;
  endtask

  // One cycle: push expectation, let combinational outputs settle, pop and
  // compare, then advance to the next falling edge.
  task automatic checkOutput(input logic [9:0] vec, input string tag);
    exp_t e;
    e.vec = vec;
    e.ret = expRet;
    e.tag = tag;
    sb.push_back(e);
    #1;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("[TB] FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      assert (obsVec === e.vec) else begin
        mismatched++;
        $error("[TB] FAIL %s strobes got %b want %b", e.tag, obsVec, e.vec);
      end
      compared++;
      assert (retired === e.ret) else begin
        mismatched++;
        $error("[TB] FAIL %s retired got %0d want %0d", e.tag, retired, e.ret);
      end
      if (e.vec[8]) expRet = expRet + 1'b1;
    end
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset   = 1'b0;
    mem_ack = 1'b0;
    expRet  = '0;
`ifdef DEBUG_STEP_EN
    step = 1'b0;
`endif
    applyStimulus(I_ALU_RF);
    @(negedge clock);
    checkOutput(10'b0, "boot_in_reset");
    reset = 1'b1;
    checkOutput(10'b0, "boot_released");

    // ALU with both writes: strobes together in EXEC.
    checkOutput(B_IR, "alu_fetch");
    checkOutput(10'b0, "alu_decode");
    checkOutput(B_PCEN | B_RW | B_FW, "alu_exec");

    // Branch not taken, then taken, then jump with flag clear.
    applyStimulus(I_BR0);
    checkOutput(B_IR, "br0_fetch");
    checkOutput(10'b0, "br0_decode");
    checkOutput(B_PCEN, "br0_exec");
    applyStimulus(I_BR1);
    checkOutput(B_IR, "br1_fetch");
    checkOutput(10'b0, "br1_decode");
    checkOutput(B_PCEN | B_PSEL, "br1_exec");
    applyStimulus(I_JMP);
    checkOutput(B_IR, "jmp_fetch");
    checkOutput(10'b0, "jmp_decode");
    checkOutput(B_PCEN | B_PSEL, "jmp_exec");

    // Load, ack after two wait cycles, then WB.
    applyStimulus(I_LOAD);
    checkOutput(B_IR, "ld_fetch");
    checkOutput(10'b0, "ld_decode");
    checkOutput(10'b0, "ld_exec");
    checkOutput(B_MREQ, "ld_wait0");
    checkOutput(B_MREQ, "ld_wait1");
    mem_ack = 1'b1;
    checkOutput(B_MREQ, "ld_ack");
    mem_ack = 1'b0;
    checkOutput(B_PCEN | B_RW | B_RMS, "ld_wb");

    // Store acked immediately.
    applyStimulus(I_STORE);
    checkOutput(B_IR, "st0_fetch");
    checkOutput(10'b0, "st0_decode");
    mem_ack = 1'b1;
    checkOutput(10'b0, "st0_exec");
    checkOutput(B_MREQ | B_MWE | B_PCEN, "st0_ack");
    mem_ack = 1'b0;

    // Store acked on the last allowed cycle: ack beats timeout.
    checkOutput(B_IR, "st14_fetch");
    checkOutput(10'b0, "st14_decode");
    checkOutput(10'b0, "st14_exec");
    for (int i = 0; i < 14; i++) checkOutput(B_MREQ | B_MWE, "st14_wait");
    mem_ack = 1'b1;
    checkOutput(B_MREQ | B_MWE | B_PCEN, "st14_ack");
    mem_ack = 1'b0;

    // Store never acked: 15 request cycles then FAULT held.
    checkOutput(B_IR, "sto_fetch");
    checkOutput(10'b0, "sto_decode");
    checkOutput(10'b0, "sto_exec");
    for (int i = 0; i < 15; i++) checkOutput(B_MREQ | B_MWE, "sto_wait");
    checkOutput(B_FLT, "fault0");
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) checkOutput(B_FLT, "fault_held");

    // Reset out of FAULT, late ack ignored in BOOT/FETCH.
    reset  = 1'b0;
    expRet = '0;
    checkOutput(10'b0, "fault_reset");
    reset = 1'b1;
    checkOutput(10'b0, "late_ack_boot");
    checkOutput(B_IR, "late_ack_fetch");
    mem_ack = 1'b0;
    checkOutput(10'b0, "mid_decode");
    checkOutput(10'b0, "mid_exec");
    checkOutput(B_MREQ | B_MWE, "mid_mem");
    #2 reset = 1'b0;
    expRet = '0;
    #1;
    compared++;
    assert (mem_req === 1'b0) else begin
      mismatched++;
      $error("[TB] FAIL async_req_drop mem_req got %b want 0", mem_req);
    end
    @(negedge clock);
    checkOutput(10'b0, "mid_reset");
    reset = 1'b1;
    checkOutput(10'b0, "halt_boot");

    // Four ALU variants, then halt (halt outranks load).
    applyStimulus(I_ALU_N);
    checkOutput(B_IR, "a0_fetch");
    checkOutput(10'b0, "a0_decode");
    checkOutput(B_PCEN, "a0_exec");
    applyStimulus(I_ALU_R);
    checkOutput(B_IR, "a1_fetch");
    checkOutput(10'b0, "a1_decode");
    checkOutput(B_PCEN | B_RW, "a1_exec");
    applyStimulus(I_ALU_F);
    checkOutput(B_IR, "a2_fetch");
    checkOutput(10'b0, "a2_decode");
    checkOutput(B_PCEN | B_FW, "a2_exec");
    applyStimulus(I_ALU_RF);
    checkOutput(B_IR, "a3_fetch");
    checkOutput(10'b0, "a3_decode");
    checkOutput(B_PCEN | B_RW | B_FW, "a3_exec");
    applyStimulus(I_HALTLD);
    checkOutput(B_IR, "h_fetch");
    checkOutput(10'b0, "h_decode");
    checkOutput(10'b0, "h_exec");
    for (int i = 0; i < 20; i++) begin
      mem_ack = i[0];
      checkOutput(B_HALT, "halt_held");
    end
    mem_ack = 1'b0;
    compared++;
    assert (retired === 16'd4) else begin
      mismatched++;
      $error("[TB] FAIL halt_retired got %0d want 4", retired);
    end

`ifdef DEBUG_STEP_EN
    // Single-step: second instruction fetched only after step at cycle 10.
    reset  = 1'b0;
    expRet = '0;
    checkOutput(10'b0, "step_reset");
    reset = 1'b1;
    checkOutput(10'b0, "step_boot");
    applyStimulus(I_ALU_RF);
    checkOutput(B_IR, "s1_fetch");
    checkOutput(10'b0, "s1_decode");
    checkOutput(B_PCEN | B_RW | B_FW, "s1_exec");
    for (int i = 4; i < 10; i++) checkOutput(10'b0, "step_wait");
    step = 1'b1;
    checkOutput(10'b0, "step_pulse");
    step = 1'b0;
    checkOutput(B_IR, "s2_fetch");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
